// File: rtl/adma2_pkg.sv
// Shared encodings and descriptor layout for the ADMA2 descriptor sequencer.
package adma2_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_FDS  = 2'b01,
        ST_CADR = 2'b10,
        ST_TFR  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ACT_NOP  = 2'b00,
        ACT_RSV  = 2'b01,
        ACT_TRAN = 2'b10,
        ACT_LINK = 2'b11
    } act_t;

    localparam int DESC_BYTES     = 8;
    localparam int DESC_ADDR_LSB  = 32;
    localparam int DESC_LEN_LSB   = 16;
    localparam int DESC_ACT_LSB   = 4;
    localparam int DESC_INT_BIT   = 2;
    localparam int DESC_END_BIT   = 1;
    localparam int DESC_VALID_BIT = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [16:0] len;   // byte count, 1..65536
        act_t        act;
        logic        irq;
        logic        last;
        logic        valid;
    } desc_fields_t;

    // Descriptor lines live on 8-byte boundaries.
    function automatic logic [31:0] align_addr(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/adma2_desc_decode.sv
// Combinational field extraction for one 64-bit ADMA2 descriptor line.
module adma2_desc_decode
    import adma2_pkg::*;
(
    input  logic [63:0]  desc,
    output desc_fields_t fields
);

    logic [15:0] raw_len;
    logic        unused_bits;

    // Reserved bits carry no meaning for the sequencer.
    assign unused_bits = ^{desc[15:6], desc[3]};

    // Split the line into fields; a zero length field encodes 64 KiB.
    always_comb begin
        raw_len      = desc[DESC_LEN_LSB +: 16];
        fields.addr  = desc[DESC_ADDR_LSB +: 32];
        fields.len   = (raw_len == 16'd0) ? 17'h10000 : {1'b0, raw_len};
        fields.act   = act_t'(desc[DESC_ACT_LSB +: 2]);
        fields.irq   = desc[DESC_INT_BIT];
        fields.last  = desc[DESC_END_BIT];
        fields.valid = desc[DESC_VALID_BIT];
    end

endmodule

// File: rtl/adma2_desc_sequencer.sv
// ADMA2 descriptor walker: fetch, decode, advance system address, hand TRAN
// lines to the data DMA, and capture the ADMA error state.
module adma2_desc_sequencer
    import adma2_pkg::*;
#(
    parameter int MAX_DESC = 1024,
    parameter int CNT_W    = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] desc_base,
    input  logic        stop,
    output logic        desc_req,
    output logic [31:0] desc_addr,
    input  logic        desc_ack,
    input  logic [63:0] desc_data,
    output logic        tfr_start,
    output logic [31:0] tfr_addr,
    output logic [16:0] tfr_len,
    input  logic        tfr_done,
    input  logic        tfr_err,
    output logic        tfr_abort,
    output logic        busy,
    output logic        done,
    output logic        int_pulse,
    output logic        adma_err,
    output logic [1:0]  err_state,
    output logic [31:0] sys_addr
);

    state_t       state, state_n;
    logic [63:0]  desc_q;
    logic [CNT_W-1:0] cnt;
    desc_fields_t fields;
    logic         unused_valid;

    // Control strobes from the next-state logic into the datapath.
    logic   do_start, ld_desc, inc_cnt, set_err, upd_addr, go_tfr;
    logic   done_n, int_n, abort_n;
    state_t err_code;

    adma2_desc_decode u_decode (
        .desc   (desc_q),
        .fields (fields)
    );

    // Validity is checked on the live fetch data, not on the latch.
    assign unused_valid = fields.valid;

    assign desc_req  = (state == ST_FDS);
    assign desc_addr = sys_addr;
    assign busy      = (state != ST_STOP);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_STOP;
        else       state <= state_n;
    end

    // Next-state and control strobes; stop beats every other event.
    always_comb begin
        state_n  = state;
        do_start = 1'b0;
        ld_desc  = 1'b0;
        inc_cnt  = 1'b0;
        set_err  = 1'b0;
        err_code = ST_STOP;
        upd_addr = 1'b0;
        go_tfr   = 1'b0;
        done_n   = 1'b0;
        int_n    = 1'b0;
        abort_n  = 1'b0;
        case (state)
            ST_STOP: begin
                if (start) begin
                    do_start = 1'b1;
                    state_n  = ST_FDS;
                end
            end
            ST_FDS: begin
                if (stop) begin
                    state_n = ST_STOP;
                end else if (desc_ack) begin
                    ld_desc = 1'b1;
                    // cnt already at MAX_DESC means this line would overrun.
                    if (!desc_data[DESC_VALID_BIT] || cnt == CNT_W'(MAX_DESC)) begin
                        set_err  = 1'b1;
                        err_code = ST_FDS;
                        state_n  = ST_STOP;
                    end else begin
                        inc_cnt = 1'b1;
                        state_n = ST_CADR;
                    end
                end
            end
            ST_CADR: begin
                if (stop) begin
                    state_n = ST_STOP;
                end else begin
                    upd_addr = 1'b1;
                    if (fields.act == ACT_TRAN) begin
                        go_tfr  = 1'b1;
                        state_n = ST_TFR;
                    end else begin
                        int_n = fields.irq;
                        if (fields.last) begin
                            done_n  = 1'b1;
                            state_n = ST_STOP;
                        end else begin
                            state_n = ST_FDS;
                        end
                    end
                end
            end
            ST_TFR: begin
                if (stop) begin
                    abort_n = 1'b1;
                    state_n = ST_STOP;
                end else if (tfr_err) begin
                    set_err  = 1'b1;
                    err_code = ST_TFR;
                    state_n  = ST_STOP;
                end else if (tfr_done) begin
                    int_n = fields.irq;
                    if (fields.last) begin
                        done_n  = 1'b1;
                        state_n = ST_STOP;
                    end else begin
                        state_n = ST_FDS;
                    end
                end
            end
            default: state_n = ST_STOP;
        endcase
    end

    // Datapath: address, latch, counter, transfer registers and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sys_addr  <= '0;
            desc_q    <= '0;
            cnt       <= '0;
            tfr_addr  <= '0;
            tfr_len   <= '0;
            tfr_start <= 1'b0;
            tfr_abort <= 1'b0;
            done      <= 1'b0;
            int_pulse <= 1'b0;
            adma_err  <= 1'b0;
            err_state <= 2'b00;
        end else begin
            tfr_start <= go_tfr;
            tfr_abort <= abort_n;
            done      <= done_n;
            int_pulse <= int_n;
            if (do_start) begin
                sys_addr  <= align_addr(desc_base);
                cnt       <= '0;
                adma_err  <= 1'b0;
                err_state <= 2'b00;
            end
            if (ld_desc) desc_q <= desc_data;
            if (inc_cnt) cnt <= cnt + 1'b1;
            if (set_err) begin
                adma_err  <= 1'b1;
                err_state <= err_code;
            end
            if (upd_addr) begin
                if (fields.act == ACT_LINK) sys_addr <= align_addr(fields.addr);
                else                        sys_addr <= sys_addr + 32'(DESC_BYTES);
            end
            if (go_tfr) begin
                tfr_addr <= fields.addr;
                tfr_len  <= fields.len;
            end
        end
    end

endmodule

// File: tb/tb_adma2_desc_sequencer.sv
// Bench for adma2_desc_sequencer: directed table, hand-written corner cases,
// and randomized descriptor tables checked against a table-walking model.
module tb_adma2_desc_sequencer;
    import adma2_pkg::*;

    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [31:0] desc_base;
    logic        desc_req, desc_ack, tfr_start, tfr_done, tfr_err, tfr_abort;
    logic        busy, done, int_pulse, adma_err;
    logic [31:0] desc_addr, tfr_addr, sys_addr;
    logic [63:0] desc_data;
    logic [16:0] tfr_len;
    logic [1:0]  err_state;

    // responder (auto) and hand-driven (manual) sources
    logic        auto_rsp;
    logic        r_ack, r_done, r_err, m_ack, m_done, m_err;
    logic [63:0] r_data, m_data;
    int          err_idx;

    assign desc_ack  = r_ack | m_ack;
    assign desc_data = m_ack ? m_data : r_data;
    assign tfr_done  = r_done | m_done;
    assign tfr_err   = r_err | m_err;

    always #5 clk = ~clk;

    adma2_desc_sequencer #(.MAX_DESC(MAXD), .CNT_W(11)) dut (
        .clk(clk), .reset(reset), .start(start), .desc_base(desc_base), .stop(stop),
        .desc_req(desc_req), .desc_addr(desc_addr), .desc_ack(desc_ack), .desc_data(desc_data),
        .tfr_start(tfr_start), .tfr_addr(tfr_addr), .tfr_len(tfr_len), .tfr_done(tfr_done),
        .tfr_err(tfr_err), .tfr_abort(tfr_abort), .busy(busy), .done(done),
        .int_pulse(int_pulse), .adma_err(adma_err), .err_state(err_state), .sys_addr(sys_addr)
    );

    logic [63:0] mem [logic [31:0]];

    function automatic logic [63:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    function automatic logic [63:0] mk(input logic [31:0] a, input logic [15:0] l,
                                       input logic [1:0] act, input logic irq,
                                       input logic last, input logic valid);
        return {a, l, 10'b0, act, 1'b0, irq, last, valid};
    endfunction

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // memory and data-DMA responders with random latency
    initial begin
        int mdly, tdly, tidx;
        logic tbusy;
        r_ack = 0; r_data = 0; r_done = 0; r_err = 0;
        mdly = 0; tdly = 0; tidx = 0; tbusy = 0;
        forever begin
            @(posedge clk); #1;
            r_ack = 0; r_done = 0; r_err = 0;
            if (start) tidx = 0;
            if (auto_rsp && desc_req) begin
                if (mdly == 0) begin
                    r_ack = 1; r_data = rd(desc_addr); mdly = $urandom_range(0, 2);
                end else mdly--;
            end
            if (auto_rsp && tbusy) begin
                if (tdly == 0) begin
                    r_done = 1;
                    if (tidx == err_idx) r_err = 1;
                    tidx++; tbusy = 0;
                end else tdly--;
            end else if (auto_rsp && tfr_start) begin
                tbusy = 1; tdly = $urandom_range(0, 3);
            end
        end
    end

    // observed events of the current operation
    logic [31:0] fetch_q[$], tfa_q[$];
    logic [16:0] tfl_q[$];
    int          n_int, n_done;

    always @(negedge clk) begin
        if (start) begin
            fetch_q.delete(); tfa_q.delete(); tfl_q.delete(); n_int = 0; n_done = 0;
        end
        if (desc_req && desc_ack) fetch_q.push_back(desc_addr);
        if (tfr_start) begin tfa_q.push_back(tfr_addr); tfl_q.push_back(tfr_len); end
        if (int_pulse) n_int++;
        if (done) n_done++;
    end

    // expected results of the current operation
    logic [31:0] e_f[$], e_ta[$];
    logic [16:0] e_tl[$];
    int          e_int, e_done;
    logic        e_err;
    logic [1:0]  e_es;
    logic [31:0] e_sys;

    // Walk the table in memory the way the host register spec describes it.
    task automatic model(input logic [31:0] base, input int eidx);
        logic [31:0] a;
        logic [63:0] d;
        int n, ti;
        e_f.delete(); e_ta.delete(); e_tl.delete();
        e_int = 0; e_done = 0; e_err = 0; e_es = 0;
        a = base & 32'hFFFF_FFF8; n = 0; ti = 0;
        for (int step = 0; step < 64; step++) begin
            d = rd(a);
            e_f.push_back(a);
            if (!d[0] || n == MAXD) begin e_err = 1; e_es = 2'b01; break; end
            n++;
            if (d[5:4] == 2'b11) a = d[63:32] & 32'hFFFF_FFF8;
            else                 a = a + 32'd8;
            if (d[5:4] == 2'b10) begin
                e_ta.push_back(d[63:32]);
                e_tl.push_back(d[31:16] == 16'd0 ? 17'h10000 : {1'b0, d[31:16]});
                if (ti == eidx) begin e_err = 1; e_es = 2'b11; break; end
                ti++;
            end
            if (d[2]) e_int++;
            if (d[1]) begin e_done = 1; break; end
        end
        e_sys = a;
    endtask

    task automatic run_op(input logic [31:0] base, input int eidx);
        int w;
        err_idx = eidx; desc_base = base; start = 1;
        tick();
        start = 0;
        chk("start_to_req", desc_req, 1);
        w = 0;
        while (busy && w < 500) begin tick(); w++; end
        if (busy) begin
            chk("op_timeout", busy, 0);
            reset = 1; tick(); reset = 0;
        end
        tick(); tick();
    endtask

    task automatic compare_all(input string tag);
        chk({tag, " nfetch"}, fetch_q.size(), e_f.size());
        for (int i = 0; i < e_f.size() && i < fetch_q.size(); i++)
            chk({tag, " fetch_addr"}, fetch_q[i], e_f[i]);
        chk({tag, " ntfr"}, tfa_q.size(), e_ta.size());
        for (int i = 0; i < e_ta.size() && i < tfa_q.size(); i++) begin
            chk({tag, " tfr_addr"}, tfa_q[i], e_ta[i]);
            chk({tag, " tfr_len"}, tfl_q[i], e_tl[i]);
        end
        chk({tag, " ints"}, n_int, e_int);
        chk({tag, " dones"}, n_done, e_done);
        chk({tag, " adma_err"}, adma_err, e_err);
        chk({tag, " err_state"}, err_state, e_es);
        chk({tag, " sys_addr"}, sys_addr, e_sys);
    endtask

    typedef struct {
        logic [31:0] base;
        int          nl;
        logic [31:0] la[2];
        logic [63:0] ld[2];
        int          eidx;
        int          nf;
        logic [31:0] fa[2];
        int          nt;
        logic [31:0] ta[2];
        logic [16:0] tl[2];
        int          ints;
        int          dones;
        logic        err;
        logic [1:0]  es;
        logic [31:0] sys;
    } vec_t;

    vec_t vec[5];

    task automatic rand_op(input int k);
        logic [31:0] base, tgt;
        logic [1:0]  act;
        logic        irq;
        int          eidx;
        mem.delete();
        for (int i = 0; i < 24; i++) begin
            act = 2'($urandom % 4);
            irq = (act == 2'b11) ? 1'b0 : 1'($urandom % 2);
            tgt = (act == 2'b11) ? 32'h1000 + 32'($urandom_range(0, 23)) * 8 + 32'($urandom_range(0, 7))
                                 : $urandom;
            mem[32'h1000 + 32'(i) * 8] = mk(tgt, ($urandom % 4 == 0) ? 16'h0 : 16'($urandom),
                                            act, irq, ($urandom % 3) == 0, ($urandom % 10) != 0);
        end
        base = 32'h1000 + 32'($urandom_range(0, 15)) * 8 + 32'($urandom_range(0, 7));
        eidx = ($urandom % 4 == 0) ? int'($urandom % 2) : -1;
        model(base, eidx);
        run_op(base, eidx);
        compare_all($sformatf("rand%0d", k));
    endtask

    initial begin
        reset = 1; start = 0; stop = 0; desc_base = 0; auto_rsp = 0; err_idx = -1;
        m_ack = 0; m_done = 0; m_err = 0; m_data = 0;

        vec[0] = '{32'h1000, 1, '{32'h1000, 32'h0}, '{64'h0, 64'h0}, -1,
                   1, '{32'h1000, 32'h0}, 0, '{32'h0, 32'h0}, '{17'h0, 17'h0},
                   0, 0, 1'b1, 2'b01, 32'h1000};
        vec[1] = '{32'h1000, 2, '{32'h1000, 32'h1008},
                   '{mk(32'h2000, 16'h0200, 2'b10, 0, 0, 1), mk(32'h3000, 16'h0, 2'b10, 1, 1, 1)}, -1,
                   2, '{32'h1000, 32'h1008}, 2, '{32'h2000, 32'h3000}, '{17'd512, 17'h10000},
                   1, 1, 1'b0, 2'b00, 32'h1010};
        vec[2] = '{32'h1000, 1, '{32'h1000, 32'h0}, '{mk(32'h6000, 16'h40, 2'b10, 1, 1, 1), 64'h0}, 0,
                   1, '{32'h1000, 32'h0}, 1, '{32'h6000, 32'h0}, '{17'h40, 17'h0},
                   0, 0, 1'b1, 2'b11, 32'h1008};
        vec[3] = '{32'h1000, 2, '{32'h1000, 32'h4000},
                   '{mk(32'h4005, 16'h0, 2'b11, 0, 0, 1), mk(32'h5000, 16'd16, 2'b10, 0, 1, 1)}, -1,
                   2, '{32'h1000, 32'h4000}, 1, '{32'h5000, 32'h0}, '{17'd16, 17'h0},
                   0, 1, 1'b0, 2'b00, 32'h4008};
        vec[4] = '{32'h1000, 1, '{32'h1000, 32'h0}, '{mk(32'h1000, 16'h0, 2'b11, 0, 0, 1), 64'h0}, -1,
                   5, '{32'h1000, 32'h1000}, 0, '{32'h0, 32'h0}, '{17'h0, 17'h0},
                   0, 0, 1'b1, 2'b01, 32'h1000};

        repeat (3) tick();
        chk("rst_flags", {desc_req, tfr_start, tfr_abort, busy, done, int_pulse, adma_err, err_state}, 0);
        chk("rst_addr", {desc_addr, tfr_addr}, 0);
        chk("rst_len_sys", {15'h0, tfr_len, sys_addr}, 0);
        reset = 0;
        tick();

        // directed table
        auto_rsp = 1;
        for (int v = 0; v < 5; v++) begin
            mem.delete();
            for (int i = 0; i < vec[v].nl; i++) mem[vec[v].la[i]] = vec[v].ld[i];
            run_op(vec[v].base, vec[v].eidx);
            e_f.delete(); e_ta.delete(); e_tl.delete();
            for (int i = 0; i < vec[v].nf; i++) e_f.push_back(vec[v].fa[i < 2 ? i : 1]);
            for (int i = 0; i < vec[v].nt; i++) begin
                e_ta.push_back(vec[v].ta[i]); e_tl.push_back(vec[v].tl[i]);
            end
            e_int = vec[v].ints; e_done = vec[v].dones; e_err = vec[v].err;
            e_es = vec[v].es; e_sys = vec[v].sys;
            compare_all($sformatf("vec%0d", v));
        end
        auto_rsp = 0;
        tick();

        // stop wins over a simultaneous desc_ack
        desc_base = 32'h1000; start = 1; tick(); start = 0;
        chk("h1_req", desc_req, 1);
        chk("h1_addr", desc_addr, 32'h1000);
        m_data = mk(32'h2000, 16'd8, 2'b10, 0, 1, 1); m_ack = 1; stop = 1;
        tick();
        m_ack = 0; stop = 0;
        chk("h1_stop", {desc_req, busy, adma_err, done, tfr_start}, 0);
        tick();

        // latencies, stable transfer regs, ignored start, stop in TFR
        desc_base = 32'h1000; start = 1; tick(); start = 0;
        m_data = mk(32'h2000, 16'h40, 2'b10, 1, 0, 1); m_ack = 1;
        tick();
        m_ack = 0;
        chk("h2_cadr_nostart", tfr_start, 0);
        tick();
        chk("h2_tfr_start", tfr_start, 1);
        chk("h2_tfr_addr", tfr_addr, 32'h2000);
        chk("h2_tfr_len", tfr_len, 17'h40);
        tick();
        chk("h2_start_pulse", tfr_start, 0);
        chk("h2_addr_stable", tfr_addr, 32'h2000);
        m_done = 1; tick(); m_done = 0;
        chk("h2_done_to_req", desc_req, 1);
        chk("h2_next_addr", desc_addr, 32'h1008);
        chk("h2_int", int_pulse, 1);
        m_data = mk(32'h3000, 16'h0, 2'b10, 0, 1, 1); m_ack = 1;
        tick();
        m_ack = 0;
        tick();
        chk("h2_len64k", tfr_len, 17'h10000);
        desc_base = 32'h9000; start = 1; tick(); start = 0;
        chk("h2_busy_ign", busy, 1);
        chk("h2_sys_ign", sys_addr, 32'h1010);
        stop = 1; tick(); stop = 0;
        chk("h2_abort", {tfr_abort, busy, done, adma_err}, 4'b1000);
        tick();
        chk("h2_abort_pulse", tfr_abort, 0);

        // reset in the middle of a transfer
        desc_base = 32'h1000; start = 1; tick(); start = 0;
        m_data = mk(32'h7000, 16'd32, 2'b10, 0, 1, 1); m_ack = 1;
        tick();
        m_ack = 0;
        tick();
        chk("h3_in_tfr", tfr_start, 1);
        reset = 1; tick(); reset = 0;
        chk("h3_rst_flags", {desc_req, tfr_start, tfr_abort, busy, done, int_pulse, adma_err, err_state}, 0);
        chk("h3_rst_addr", {desc_addr, tfr_addr}, 0);
        chk("h3_rst_len_sys", {15'h0, tfr_len, sys_addr}, 0);
        tick();

        // randomized tables against the model
        auto_rsp = 1;
        for (int k = 0; k < 40; k++) rand_op(k);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // hard stop in case something wedges outside the bounded waits
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
